// File: rtl/cs_pkg.sv
// Shared constants for the CS result output path.
package cs_pkg;
    localparam int CS_DW     = 10;
    localparam int CS_WIN    = 9;
    localparam int CS_DROP_W = 16;
endpackage

// File: rtl/cs_fifo_mem.sv
// FIFO storage for cs_out_fifo: one write port, asynchronous read, no reset.
module cs_fifo_mem #(
    parameter int DW    = 10,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Show-ahead head word: read is combinational from the read pointer.
    assign rdata = mem[raddr];

endmodule

// File: rtl/cs_out_fifo.sv
// Output buffer for CS result words: discards warm-up results, then pushes Y every clock.
// Optional drop counter is built when CS_OUTFIFO_DROPCNT_EN is defined.
module cs_out_fifo
    import cs_pkg::*;
#(
    parameter int DW     = CS_DW,
    parameter int DEPTH  = 16,
    parameter int WARMUP = CS_WIN
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DW-1:0]            Y,
    input  logic                     flush,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [DW-1:0]            out_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [CS_DROP_W-1:0]     drop_cnt
);

    localparam int AW  = $clog2(DEPTH);
    localparam int PW  = AW + 1;
    localparam int WCW = (WARMUP < 1) ? 1 : $clog2(WARMUP + 1);

    logic [PW-1:0]  wr_ptr_reg;
    logic [PW-1:0]  rd_ptr_reg;
    logic [WCW-1:0] warm_cnt_reg;
    logic           overflow_reg;

    logic           warm_done;
    logic           empty;
    logic           full;
    logic           pop;
    logic           push;
    logic           drop;
    logic [DW-1:0]  head_word;

    assign warm_done = (warm_cnt_reg >= WCW'(WARMUP));
    assign empty     = (wr_ptr_reg == rd_ptr_reg);
    // Same slot index but opposite lap bit means the writer is a full lap ahead.
    assign full      = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                       (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

    assign pop  = !empty && out_ready && !flush;
    assign push = warm_done && !flush && (!full || pop);
    assign drop = warm_done && !flush && full && !pop;

    cs_fifo_mem #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_reg[AW-1:0]),
        .wdata (Y),
        .raddr (rd_ptr_reg[AW-1:0]),
        .rdata (head_word)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            warm_cnt_reg <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (!warm_done) begin
                warm_cnt_reg <= warm_cnt_reg + WCW'(1);
            end
            if (flush) begin
                wr_ptr_reg   <= '0;
                rd_ptr_reg   <= '0;
                overflow_reg <= 1'b0;
            end else begin
                wr_ptr_reg <= wr_ptr_reg + PW'(push);
                rd_ptr_reg <= rd_ptr_reg + PW'(pop);
                if (drop) begin
                    overflow_reg <= 1'b1;
                end
            end
        end
    end

`ifdef CS_OUTFIFO_DROPCNT_EN
    logic [CS_DROP_W-1:0] drop_cnt_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_cnt_reg <= '0;
        end else if (flush) begin
            drop_cnt_reg <= '0;
        end else if (drop && (drop_cnt_reg != {CS_DROP_W{1'b1}})) begin
            drop_cnt_reg <= drop_cnt_reg + CS_DROP_W'(1);
        end
    end

    assign drop_cnt = drop_cnt_reg;
`else
    assign drop_cnt = '0;
`endif

    assign out_valid = !empty;
    assign out_data  = empty ? '0 : head_word;
    assign level     = wr_ptr_reg - rd_ptr_reg;
    assign overflow  = overflow_reg;

endmodule

// File: tb/tb_cs_out_fifo.sv
// Randomized and directed bench for cs_out_fifo against a queue-based reference model.
module tb_cs_out_fifo;

    localparam int DW     = 10;
    localparam int DEPTH  = 16;
    localparam int WARMUP = 9;

    logic          clk;
    logic          reset;
    logic [DW-1:0] Y;
    logic          flush;
    logic          out_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [4:0]    level;
    logic          overflow;
    logic [15:0]   drop_cnt;

    cs_out_fifo #(.DW(DW), .DEPTH(DEPTH), .WARMUP(WARMUP)) dut (
        .clk       (clk),
        .reset     (reset),
        .Y         (Y),
        .flush     (flush),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .level     (level),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: stored words, warm-up edge count, sticky flag, drop total.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] obs[$];
    int            m_warm;
    bit            m_ovf;
    int            m_dcnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_dcnt();
`ifdef CS_OUTFIFO_DROPCNT_EN
        return m_dcnt;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        mq.delete();
        m_warm = 0;
        m_ovf  = 1'b0;
        m_dcnt = 0;
    endtask

    task automatic check_outputs(input string ph);
        chk({ph, ".valid"}, 32'(out_valid), 32'(mq.size() > 0));
        chk({ph, ".data"},  32'(out_data),  (mq.size() > 0) ? 32'(mq[0]) : 32'd0);
        chk({ph, ".level"}, 32'(level),     32'(mq.size()));
        chk({ph, ".ovf"},   32'(overflow),  32'(m_ovf));
        chk({ph, ".dcnt"},  32'(drop_cnt),  32'(exp_dcnt()));
    endtask

    // Called just after a falling edge: check state, drive inputs, predict next rising edge.
    task automatic step(input string ph, input logic [DW-1:0] y, input bit f, input bit r);
        bit mpop;
        Y = y; flush = f; out_ready = r;
        check_outputs(ph);
        if (out_valid && r && !f) obs.push_back(out_data);
        mpop = (mq.size() > 0) && r && !f;
        if (f) begin
            mq.delete();
            m_ovf  = 1'b0;
            m_dcnt = 0;
        end else begin
            if (mpop) void'(mq.pop_front());
            if (m_warm >= WARMUP) begin
                if (mq.size() < DEPTH) mq.push_back(y);
                else begin
                    m_ovf = 1'b1;
                    if (m_dcnt < 65535) m_dcnt++;
                end
            end
        end
        if (m_warm < WARMUP) m_warm++;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; Y = '0; flush = 1'b0; out_ready = 1'b0;
        model_reset();
        #2;
        chk("rst.valid", 32'(out_valid), 0);
        chk("rst.data",  32'(out_data),  0);
        chk("rst.level", 32'(level),     0);
        chk("rst.ovf",   32'(overflow),  0);
        chk("rst.dcnt",  32'(drop_cnt),  0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Warm-up: Y = 1..12 with consumer ready, then one more edge to drain 12.
        for (int i = 1; i <= 13; i++) step("warm", DW'(i), 1'b0, 1'b1);
        chk("warm.nobs", obs.size(), 3);
        if (obs.size() == 3) begin
            chk("warm.obs0", 32'(obs[0]), 32'h00A);
            chk("warm.obs1", 32'(obs[1]), 32'h00B);
            chk("warm.obs2", 32'(obs[2]), 32'h00C);
        end
        chk("warm.ovf", 32'(overflow), 0);
        $display("warm-up phase done, popped %0d words", obs.size());

        // Fill from empty: 20 pushes with no consumer, last 4 dropped.
        step("flush0", 10'h3FF, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) step("fill", DW'(100 + i), 1'b0, 1'b0);
        chk("fill.level", 32'(level), 16);
        chk("fill.ovf",   32'(overflow), 1);
`ifdef CS_OUTFIFO_DROPCNT_EN
        chk("fill.dcnt",  32'(drop_cnt), 4);
`else
        chk("fill.dcnt",  32'(drop_cnt), 0);
`endif
        chk("fill.head",  32'(out_data), 100);
        $display("fill phase done, level=%0d", level);

        // Full with simultaneous pop: level holds, head advances, no new drop.
        step("fullpop", 10'd200, 1'b0, 1'b1);
        chk("fullpop.level", 32'(level), 16);
        chk("fullpop.head",  32'(out_data), 101);
        $display("full-with-pop done, head=%0d", out_data);

        // Flush from full with overflow set; next word accepted immediately.
        step("flush1", 10'd300, 1'b1, 1'b1);
        chk("flush.level", 32'(level), 0);
        chk("flush.valid", 32'(out_valid), 0);
        chk("flush.data",  32'(out_data), 0);
        chk("flush.ovf",   32'(overflow), 0);
        chk("flush.dcnt",  32'(drop_cnt), 0);
        for (int i = 0; i < 5; i++) step("post", DW'(400 + i), 1'b0, 1'b0);
        chk("post.level", 32'(level), 5);
        chk("post.head",  32'(out_data), 400);
        $display("flush phase done, level=%0d", level);

        // Mid-run asynchronous reset with 7 words buffered.
        step("flush2", 10'd0, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) step("pre_rst", DW'(500 + i), 1'b0, 1'b0);
        chk("pre_rst.level", 32'(level), 7);
        #2 reset = 1'b0;
        model_reset();
        #1;
        chk("midrst.valid", 32'(out_valid), 0);
        chk("midrst.data",  32'(out_data), 0);
        chk("midrst.level", 32'(level), 0);
        chk("midrst.ovf",   32'(overflow), 0);
        chk("midrst.dcnt",  32'(drop_cnt), 0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < WARMUP; i++) step("rewarm", DW'(600 + i), 1'b0, 1'b0);
        chk("rewarm.level", 32'(level), 0);
        step("rewarm1", 10'd700, 1'b0, 1'b0);
        chk("rewarm1.level", 32'(level), 1);
        $display("mid-run reset done, level=%0d", level);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 1500; i++) begin
            step("rand", DW'($urandom), ($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0) ^ (i[8]));
        end
        check_outputs("final");
        $display("random phase done, level=%0d overflow=%0d drop_cnt=%0d", level, overflow, drop_cnt);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cs_out_fifo.md
CS_OUT_FIFO -- requirements
Module: cs_out_fifo

Interface
REQ-001 Parameter DW, default 10, width of a CS result word Y.
REQ-002 Parameter DEPTH, default 16, FIFO entries; power of two, at least 2.
REQ-003 Parameter WARMUP, default 9, number of post-reset clock edges whose Y is not a valid result.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 Y  input  DW  CS result word; one new word presented every clock.
REQ-007 flush  input  1  synchronous clear of buffered contents.
REQ-008 out_ready  input  1  consumer accepts the head word this cycle.
REQ-009 out_valid  output  1  head word present.
REQ-010 out_data  output  DW  head word (show-ahead).
REQ-011 level  output  log2(DEPTH)+1  number of stored words.
REQ-012 overflow  output  1  sticky: at least one valid Y was dropped.
REQ-013 drop_cnt  output  16  count of dropped valid Y words (see Configuration).

Function
REQ-014 Warm-up counter shall count rising edges after reset release and saturate at WARMUP; Y sampled while the count < WARMUP shall be discarded, not counted as a drop.
REQ-015 Once warm-up completes, Y shall be a valid push on every rising edge.
REQ-016 Pop shall occur on an edge where out_valid=1 and out_ready=1.
REQ-017 A pushed word shall appear on out_data/out_valid on the first edge after the push when the FIFO was empty (1-cycle latency).
REQ-018 out_data shall be 0 whenever out_valid=0.
REQ-019 Push and pop on the same edge shall both occur; level unchanged; this applies when full.
REQ-020 Push while full without pop shall drop the incoming word, set overflow, and increment drop_cnt.
REQ-021 Pop while empty shall not occur (out_valid=0); pointers unchanged.
REQ-022 Read/write pointers shall wrap modulo DEPTH; the pointer MSB distinguishes full from empty.
REQ-023 flush=1 shall on the next edge empty the FIFO (level 0), clear overflow and drop_cnt; a concurrent push or pop is ignored and not counted as a drop.
REQ-024 flush shall not restart the warm-up counter.
REQ-025 drop_cnt shall saturate at 0xFFFF.

Reset
REQ-026 reset=0 shall asynchronously force: pointers 0, level 0, out_valid 0, out_data 0, overflow 0, drop_cnt 0, warm-up count 0.
REQ-027 Reset asserted mid-stream shall discard all buffered words; warm-up restarts from 0 on release.
REQ-028 FIFO storage array need not be reset.

Configuration
REQ-029 Macro CS_OUTFIFO_DROPCNT_EN defined: drop_cnt is implemented per REQ-020/023/025.
REQ-030 Macro not defined: drop_cnt is tied to 0, no counter flops; overflow behaviour unchanged.

Structure
REQ-031 Package cs_pkg shall hold CS_DW (10), CS_WIN (9, the default WARMUP), and the drop-counter width constant.
REQ-032 Storage shall be a sub-module cs_fifo_mem: DEPTH x DW, one write port, one asynchronous read port, no reset.
REQ-033 Pointer, level, flag and warm-up logic shall reside in cs_out_fifo.

Verification
REQ-034 Warm-up: reset release, Y=0x001..0x00C over 12 edges, out_ready=1 -> outputs exactly 0x00A,0x00B,0x00C, one per cycle; no drops.
REQ-035 Fill: after warm-up, out_ready=0 for 20 edges with Y incrementing -> level=16, overflow=1, drop_cnt=4, first 16 words retained in order.
REQ-036 Full with pop: level=16, out_ready=1 for 1 edge with a new Y -> level stays 16, head advances, drop_cnt unchanged.
REQ-037 Flush: level=5, overflow=1, flush=1 for one edge -> level=0, out_valid=0, out_data=0, overflow=0, drop_cnt=0; the next Y is accepted without a new warm-up.
REQ-038 Mid-run reset: level=7, reset pulsed low -> all outputs 0 immediately; the next 9 Y discarded after release.
REQ-039 Build without CS_OUTFIFO_DROPCNT_EN, rerun REQ-035 -> overflow=1, drop_cnt=0.
